// File: rtl/sram_like_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : sram_like_responder_if
// Purpose  : SRAM-like request/response bus. A request is accepted on a
//            rising clock when req & addr_ok; each accepted request is
//            answered later by a one-cycle data_ok pulse carrying rdata.
// Signals  : req, wr, size[1:0], addr[31:0], wstrb[3:0], wdata[31:0]
//              - driven by the master
//            addr_ok, data_ok, rdata[31:0]
//              - driven by the slave (responder)
// Modports : master (requester side), slave (responder side)
// Revision : 1.0 - initial release
// ============================================================================
interface sram_like_responder_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, addr, wstrb, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, addr, wstrb, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface
`default_nettype wire

// File: rtl/sram_like_responder.sv
`default_nettype none
// ============================================================================
// Module   : sram_like_responder
// Purpose  : Memory-backed responder for an SRAM-like bus. Writes land in
//            the backing store on the accepting edge; reads snapshot the
//            addressed word on the accepting edge. Every accepted request
//            is queued and answered in order with a one-cycle data_ok once
//            LATENCY cycles have elapsed since acceptance.
// Params   : OUTSTANDING - queue depth (power of 2, >= 2)
//            LATENCY     - accept-to-earliest-data_ok cycles (>= 1)
//            MEM_WORDS   - backing store depth in 32-bit words (power of 2)
// Ports    : clk   - rising-edge clock
//            reset - asynchronous active-high reset
//            bus   - sram_like_responder_if.slave request/response bus
// Revision : 1.0 - initial release
// ============================================================================
module sram_like_responder #(
  parameter int OUTSTANDING = 4,
  parameter int LATENCY     = 2,
  parameter int MEM_WORDS   = 1024
) (
  input  wire logic               clk,
  input  wire logic               reset,
  sram_like_responder_if.slave    bus
);

  localparam int c_PTR_W = $clog2(OUTSTANDING);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam int c_IDX_W = $clog2(MEM_WORDS);
  localparam int c_AGE_W = $clog2(LATENCY + 1);

  localparam logic [c_CNT_W-1:0] c_FULL_CNT = c_CNT_W'(OUTSTANDING);
  localparam logic [c_AGE_W-1:0] c_LAT_AGE  = c_AGE_W'(LATENCY);
  localparam logic [c_AGE_W-1:0] c_AGE_ONE  = c_AGE_W'(1);

  // Backing store (never reset) and response-queue payload.
  logic [31:0]        r_mem    [MEM_WORDS];
  logic [31:0]        r_q_data [OUTSTANDING];
  logic               r_q_wr   [OUTSTANDING];
  logic [1:0]         r_q_size [OUTSTANDING];

  // Queue control state.
  logic [c_AGE_W-1:0] r_age    [OUTSTANDING];
  logic [c_PTR_W-1:0] r_wptr;
  logic [c_PTR_W-1:0] r_rptr;
  logic [c_CNT_W-1:0] r_count;
  logic [31:0]        r_rdata;

  logic [c_IDX_W-1:0] w_idx;
  logic               w_accept;
  logic               w_data_ok;
  logic               w_addr_ok;
  logic [31:0]        w_head_rdata;

  assign w_idx = bus.addr[c_IDX_W+1:2];

  // Head is answered in the very first cycle its age reaches LATENCY.
  // Age is 1 in the cycle after acceptance, so this lands exactly LATENCY
  // cycles after the accepting cycle.
  assign w_data_ok    = (r_count != '0) && (r_age[r_rptr] >= c_LAT_AGE);
  assign w_head_rdata = r_q_wr[r_rptr] ? 32'h0 : r_q_data[r_rptr];

  // A retiring head frees a slot in the same cycle, so a full queue can
  // still accept while data_ok is high; this keeps one request per cycle.
  assign w_addr_ok = (r_count < c_FULL_CNT) | w_data_ok;
  assign w_accept  = bus.req & w_addr_ok;

  assign bus.addr_ok = w_addr_ok;
  assign bus.data_ok = w_data_ok;
  // Response data is shown combinationally in the data_ok cycle and held
  // from the register afterwards.
  assign bus.rdata   = w_data_ok ? w_head_rdata : r_rdata;

  // Memory and queue payload: no reset; memory contents survive reset and
  // stale payload is never observed because count gates data_ok.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_q_wr[r_wptr]   <= bus.wr;
      r_q_size[r_wptr] <= bus.size;
      // Non-blocking read sees every write accepted on earlier edges.
      r_q_data[r_wptr] <= r_mem[w_idx];
      if (bus.wr) begin
        for (int b = 0; b < 4; b++) begin
          if (bus.wstrb[b]) begin
            r_mem[w_idx][8*b +: 8] <= bus.wdata[8*b +: 8];
          end
        end
      end
    end
  end

  // Queue control.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_rdata <= '0;
      for (int i = 0; i < OUTSTANDING; i++) begin
        r_age[i] <= '0;
      end
    end else begin
      for (int i = 0; i < OUTSTANDING; i++) begin
        if (w_accept && (r_wptr == c_PTR_W'(i))) begin
          r_age[i] <= c_AGE_ONE;
        end else if (r_age[i] < c_LAT_AGE) begin
          r_age[i] <= r_age[i] + c_AGE_ONE;
        end
      end

      if (w_accept) begin
        r_wptr <= r_wptr + 1'b1;
      end

      if (w_data_ok) begin
        r_rptr  <= r_rptr + 1'b1;
        r_rdata <= w_head_rdata;
      end

      case ({w_accept, w_data_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Size is recorded with each request but does not affect the data path;
  // upper and sub-word address bits alias onto the same word.
  logic w_unused_bits;
  assign w_unused_bits = &{1'b0, r_q_size[r_rptr],
                           bus.addr[31:c_IDX_W+2], bus.addr[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_sram_like_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_like_responder
// Purpose  : Directed self-checking bench for sram_like_responder. One
//            instance runs with LATENCY=2, a second with LATENCY=6 to
//            exercise the full-queue / simultaneous accept-retire case.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_like_responder;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  sram_like_responder_if bus ();
  sram_like_responder_if bus6 ();

  sram_like_responder #(
    .OUTSTANDING(4), .LATENCY(2), .MEM_WORDS(1024)
  ) u_dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  sram_like_responder #(
    .OUTSTANDING(4), .LATENCY(6), .MEM_WORDS(1024)
  ) u_dut6 (
    .clk(clk), .reset(reset), .bus(bus6)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to the next cycle; inputs are driven and outputs sampled 1ns
  // after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic [31:0] a,
                       input logic [3:0] s, input logic [31:0] d);
    bus.req   = 1'b1;
    bus.wr    = w;
    bus.size  = 2'd2;
    bus.addr  = a;
    bus.wstrb = s;
    bus.wdata = d;
  endtask

  // Idle with junk on the other inputs; they must be ignored.
  task automatic idle();
    bus.req   = 1'b0;
    bus.wr    = 1'b1;
    bus.addr  = 32'h0000_0010;
    bus.wstrb = 4'hF;
    bus.wdata = 32'h5555_5555;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    bus6.req = 1'b0; bus6.wr = 1'b0; bus6.size = 2'd2;
    bus6.addr = '0; bus6.wstrb = '0; bus6.wdata = '0;
    tick(); tick();

    check("rst_addr_ok", 32'(bus.addr_ok), 32'd1);
    check("rst_data_ok", 32'(bus.data_ok), 32'd0);
    check("rst_rdata",   bus.rdata,        32'h0);
    reset = 1'b0;

    // Full write then read back.
    tick(); drive(1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF);
    #1 check("wr_addr_ok", 32'(bus.addr_ok), 32'd1);
    tick(); idle();
    check("wr_early", 32'(bus.data_ok), 32'd0);
    tick();
    check("wr_dok",   32'(bus.data_ok), 32'd1);
    check("wr_rdata", bus.rdata,        32'h0);
    tick(); drive(1'b0, 32'h10, 4'h0, 32'h0);
    check("gap_dok",  32'(bus.data_ok), 32'd0);
    tick(); idle();
    check("rd_early", 32'(bus.data_ok), 32'd0);
    tick();
    check("rd_dok",   32'(bus.data_ok), 32'd1);
    check("rd_rdata", bus.rdata,        32'hDEAD_BEEF);
    tick();
    check("rd_dok_off", 32'(bus.data_ok), 32'd0);
    check("rd_hold",    bus.rdata,        32'hDEAD_BEEF);

    // Byte-enable write of byte 1 only, read right behind it.
    drive(1'b1, 32'h10, 4'b0010, 32'h0000_AB00);
    tick(); drive(1'b0, 32'h10, 4'h0, 32'h0);
    tick(); idle();
    check("be_wr_rdata", bus.rdata, 32'h0);
    tick();
    check("be_rd_dok",   32'(bus.data_ok), 32'd1);
    check("be_rd_rdata", bus.rdata,        32'hDEAD_ABEF);

    // wstrb=0 still answered, memory unchanged.
    tick(); drive(1'b1, 32'h10, 4'h0, 32'hFFFF_FFFF);
    tick(); drive(1'b0, 32'h10, 4'h0, 32'h0);
    tick(); idle();
    check("nostrb_dok",   32'(bus.data_ok), 32'd1);
    check("nostrb_rdata", bus.rdata,        32'h0);
    tick();
    check("nostrb_rd", bus.rdata, 32'hDEAD_ABEF);

    // Back-to-back write then read of the same word.
    tick(); drive(1'b1, 32'h20, 4'hF, 32'h1234_5678);
    tick(); drive(1'b0, 32'h20, 4'h0, 32'h0);
    tick(); idle();
    check("b2b_wr_dok", 32'(bus.data_ok), 32'd1);
    tick();
    check("b2b_rd_dok",   32'(bus.data_ok), 32'd1);
    check("b2b_rd_rdata", bus.rdata,        32'h1234_5678);

    // Address aliasing: 0x1010 and 0x0013 map to the same word.
    tick(); drive(1'b1, 32'h1010, 4'hF, 32'hCAFE_F00D);
    tick(); drive(1'b0, 32'h13, 4'h0, 32'h0);
    tick(); idle();
    tick();
    check("alias_rdata", bus.rdata, 32'hCAFE_F00D);

    // Four reads on consecutive cycles: one response per cycle.
    tick(); drive(1'b0, 32'h10, 4'h0, 32'h0);
    tick(); drive(1'b0, 32'h20, 4'h0, 32'h0);
    tick(); drive(1'b0, 32'h10, 4'h0, 32'h0);
    check("tp0_dok",   32'(bus.data_ok), 32'd1);
    check("tp0_rdata", bus.rdata,        32'hCAFE_F00D);
    tick(); drive(1'b0, 32'h20, 4'h0, 32'h0);
    check("tp1_rdata",   bus.rdata,        32'h1234_5678);
    check("tp1_addr_ok", 32'(bus.addr_ok), 32'd1);
    tick(); idle();
    check("tp2_rdata", bus.rdata, 32'hCAFE_F00D);
    tick();
    check("tp3_rdata", bus.rdata, 32'h1234_5678);
    tick();
    check("tp_done", 32'(bus.data_ok), 32'd0);

    // LATENCY=6, req held: fills in 4 cycles, stalls 2, then accept+retire.
    bus6.req = 1'b1;
    for (int c = 0; c < 7; c++) begin
      check($sformatf("lat6_addr_ok_c%0d", c), 32'(bus6.addr_ok),
            (c < 4 || c == 6) ? 32'd1 : 32'd0);
      check($sformatf("lat6_data_ok_c%0d", c), 32'(bus6.data_ok),
            (c == 6) ? 32'd1 : 32'd0);
      tick();
    end
    check("lat6_count", 32'(u_dut6.r_count), 32'd4);
    bus6.req = 1'b0;

    // Reset with two reads outstanding discards them.
    drive(1'b0, 32'h10, 4'h0, 32'h0);
    tick(); drive(1'b0, 32'h20, 4'h0, 32'h0);
    tick(); idle();
    reset = 1'b1;
    #1;
    check("mid_rst_dok",     32'(bus.data_ok), 32'd0);
    check("mid_rst_addr_ok", 32'(bus.addr_ok), 32'd1);
    check("mid_rst_rdata",   bus.rdata,        32'h0);
    tick();
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("post_rst_dok_c%0d", c), 32'(bus.data_ok), 32'd0);
      check($sformatf("post_rst6_dok_c%0d", c), 32'(bus6.data_ok), 32'd0);
      tick();
    end

    // Memory survives reset.
    drive(1'b0, 32'h10, 4'h0, 32'h0);
    tick(); idle();
    tick();
    check("persist_dok",   32'(bus.data_ok), 32'd1);
    check("persist_rdata", bus.rdata,        32'hCAFE_F00D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
